// File: rtl/mainfsm_pkg.sv
// Shared types for the parametrised multicycle main control FSM.
package mainfsm_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECUTER = 4'd2,
        S_EXECUTEI = 4'd3,
        S_MULWAIT  = 4'd4,
        S_FPWAIT   = 4'd5,
        S_ALUWB    = 4'd6,
        S_MEMADR   = 4'd7,
        S_MEMRD    = 4'd8,
        S_MEMWR    = 4'd9,
        S_MEMWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_UNKNOWN  = 4'd12
    } state_e;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
    localparam logic [1:0] CAUSE_FP_TIMEOUT = 2'b10;

    // Datapath control vector, MSB first in the order the datapath lists it.
    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       mem_w;
        logic       reg_w;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic       we4w;
        logic       result_control;
    } ctrl_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mainfsm_waitctr.sv
// Loadable down-counter with terminal-count flag; shared by the multiply stall and FP timeout.
module mainfsm_waitctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mainfsm_param.sv
// Multicycle main control FSM with memory wait states, multiply stall and FP handshake/timeout.
// Optional performance counters are built when MAINFSM_PERF_CNT_EN is defined.
module mainfsm_param
    import mainfsm_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned FP_TIMEOUT = 15,
    parameter logic [3:0]  MULL_ID    = 4'b1001,
    parameter logic [4:0]  FP_ID      = 5'b11111,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       MULL_Identifier,
    input  logic [4:0]       FP_identifier,
    input  logic             mem_ready,
    input  logic             fp_done,
    output logic             NextPC,
    output logic             Branch,
    output logic             MemW,
    output logic             RegW,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ALUOp,
    output logic             WE4w,
    output logic             ResultControl,
    output logic             mul_start,
    output logic             fp_start,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_MAX = max_u(MUL_CYCLES, FP_TIMEOUT);
    localparam int unsigned WAIT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam int unsigned MUL_LOAD = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
    localparam int unsigned FP_LOAD  = FP_TIMEOUT - 1;

    state_e              state_q, state_d;
    logic                started_q;
    ctrl_t               ctrl_c;
    logic                mul_start_c, fp_start_c, trap_c;
    logic [1:0]          cause_c;
    logic                ctr_load_c, ctr_en_c, ctr_tc;
    logic [WAIT_W-1:0]   ctr_val_c;
    logic                is_mul_c, is_fp_c;
    logic                unused_funct_c;

    assign is_mul_c = (Op == 2'b00) && !Funct[5] && (MULL_Identifier == MULL_ID);
    assign is_fp_c  = (Op == 2'b00) && !Funct[5] && (FP_identifier == FP_ID) && !is_mul_c;
    assign unused_funct_c = ^{Funct[4], Funct[2:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    mainfsm_waitctr #(.W(WAIT_W)) u_waitctr (
        .clk        (clk),
        .rst        (reset),
        .load_i     (ctr_load_c),
        .load_val_i (ctr_val_c),
        .en_i       (ctr_en_c),
        .tc_o       (ctr_tc)
    );

    always_comb begin
        state_d     = state_q;
        ctrl_c      = '0;
        mul_start_c = 1'b0;
        fp_start_c  = 1'b0;
        trap_c      = 1'b0;
        cause_c     = CAUSE_NONE;
        ctr_load_c  = 1'b0;
        ctr_val_c   = '0;
        ctr_en_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.result_src = 2'b10;
                ctrl_c.alu_src_a  = 2'b01;
                ctrl_c.alu_src_b  = 2'b10;
                ctrl_c.next_pc    = mem_ready;
                ctrl_c.ir_write   = mem_ready;
                // No decode until the first fetch after reset has actually latched IR.
                if (mem_ready && started_q) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl_c.result_src = 2'b10;
                ctrl_c.alu_src_a  = 2'b01;
                ctrl_c.alu_src_b  = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_EXECUTER: begin
                ctrl_c.result_src = 2'b10;
                ctrl_c.alu_op     = 1'b1;
                if (is_fp_c) begin
                    ctrl_c.result_control = 1'b1;
                    fp_start_c = 1'b1;
                    ctr_load_c = 1'b1;
                    ctr_val_c  = WAIT_W'(FP_LOAD);
                    state_d    = S_FPWAIT;
                end else if (is_mul_c) begin
                    mul_start_c = 1'b1;
                    if (MUL_CYCLES > 1) begin
                        ctr_load_c = 1'b1;
                        ctr_val_c  = WAIT_W'(MUL_LOAD);
                        state_d    = S_MULWAIT;
                    end else begin
                        state_d = S_ALUWB;
                    end
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_EXECUTEI: begin
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.alu_op    = 1'b1;
                state_d          = S_ALUWB;
            end
            S_MULWAIT: begin
                ctrl_c.result_src = 2'b10;
                ctrl_c.alu_op     = 1'b1;
                ctr_en_c          = 1'b1;
                if (ctr_tc) state_d = S_ALUWB;
            end
            S_FPWAIT: begin
                ctrl_c.result_control = 1'b1;
                ctrl_c.alu_op         = 1'b1;
                ctr_en_c              = 1'b1;
                // A result arriving in the final timeout cycle still completes normally.
                if (fp_done) begin
                    state_d = S_ALUWB;
                end else if (ctr_tc) begin
                    trap_c  = 1'b1;
                    cause_c = CAUSE_FP_TIMEOUT;
                    state_d = S_FETCH;
                end
            end
            S_ALUWB: begin
                ctrl_c.reg_w          = 1'b1;
                ctrl_c.alu_op         = 1'b1;
                ctrl_c.we4w           = is_mul_c & Funct[3];
                ctrl_c.result_control = is_fp_c;
                state_d               = S_FETCH;
            end
            S_MEMADR: begin
                ctrl_c.result_src = 2'b10;
                ctrl_c.alu_src_b  = 2'b01;
                state_d           = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl_c.adr_src   = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                ctrl_c.mem_w     = 1'b1;
                ctrl_c.adr_src   = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                ctrl_c.reg_w      = 1'b1;
                ctrl_c.adr_src    = 1'b1;
                ctrl_c.result_src = 2'b01;
                ctrl_c.alu_src_b  = 2'b01;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.branch     = 1'b1;
                ctrl_c.result_src = 2'b10;
                ctrl_c.alu_src_a  = 2'b10;
                ctrl_c.alu_src_b  = 2'b01;
                state_d           = S_FETCH;
            end
            S_UNKNOWN: begin
                trap_c  = 1'b1;
                cause_c = CAUSE_ILLEGAL;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes stay quiet until the first clock after reset release.
    assign NextPC        = ctrl_c.next_pc  & started_q;
    assign Branch        = ctrl_c.branch   & started_q;
    assign MemW          = ctrl_c.mem_w    & started_q;
    assign RegW          = ctrl_c.reg_w    & started_q;
    assign IRWrite       = ctrl_c.ir_write & started_q;
    assign WE4w          = ctrl_c.we4w     & started_q;
    assign AdrSrc        = ctrl_c.adr_src;
    assign ResultSrc     = ctrl_c.result_src;
    assign ALUSrcA       = ctrl_c.alu_src_a;
    assign ALUSrcB       = ctrl_c.alu_src_b;
    assign ALUOp         = ctrl_c.alu_op;
    assign ResultControl = ctrl_c.result_control;
    assign mul_start     = mul_start_c & started_q;
    assign fp_start      = fp_start_c & started_q;
    assign trap          = trap_c & started_q;
    assign trap_cause    = (trap_c & started_q) ? cause_c : CAUSE_NONE;
    assign state_o       = state_q;

`ifdef MAINFSM_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, stall_q;
    logic             retire_c, stall_c;

    assign retire_c = started_q && (state_q != S_FETCH) && (state_d == S_FETCH) && !trap_c;
    assign stall_c  = started_q &&
                      ((((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) && !mem_ready) ||
                       (state_q == S_MULWAIT) || (state_q == S_FPWAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire_c) retired_q <= retired_q + CNT_W'(1);
            if (stall_c)  stall_q   <= stall_q + CNT_W'(1);
        end
    end

    assign instr_retired = retired_q;
    assign stall_cycles  = stall_q;
`else
    assign instr_retired = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_mainfsm_param.sv
// Self-checking bench: per-instruction expected cycle traces built from the control rules, replayed against the DUT.
module tb_mainfsm_param;
    import mainfsm_pkg::*;

    localparam int unsigned MUL_CYCLES = 3;
    localparam int unsigned FP_TIMEOUT = 15;
    localparam int unsigned CNT_W      = 32;

    typedef struct packed {
        logic np, br, mw, rw, irw, adr;
        logic [1:0] rs, a, b;
        logic aop, we, rc, ms, fs, tr;
        logic [1:0] cause;
    } exp_t;

    typedef struct {
        state_e st;
        exp_t   o;
        logic   mr;
        logic   fd;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] MULL_Identifier;
    logic [4:0] FP_identifier;
    logic mem_ready, fp_done;
    logic NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ALUOp, WE4w, ResultControl;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, trap_cause;
    logic mul_start, fp_start, trap;
    logic [3:0] state_o;
    logic [CNT_W-1:0] instr_retired, stall_cycles;
    logic [19:0] dut_outs;

    step_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic [CNT_W-1:0] exp_stall = '0;

    always #5 clk = ~clk;

    mainfsm_param #(
        .MUL_CYCLES(MUL_CYCLES), .FP_TIMEOUT(FP_TIMEOUT),
        .MULL_ID(4'b1001), .FP_ID(5'b11111), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .MULL_Identifier(MULL_Identifier), .FP_identifier(FP_identifier),
        .mem_ready(mem_ready), .fp_done(fp_done),
        .NextPC(NextPC), .Branch(Branch), .MemW(MemW), .RegW(RegW), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .WE4w(WE4w), .ResultControl(ResultControl),
        .mul_start(mul_start), .fp_start(fp_start), .trap(trap), .trap_cause(trap_cause),
        .state_o(state_o), .instr_retired(instr_retired), .stall_cycles(stall_cycles)
    );

    assign dut_outs = {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                       ALUOp, WE4w, ResultControl, mul_start, fp_start, trap, trap_cause};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic push(input state_e st, input exp_t o, input logic mr, input logic fd);
        step_t s;
        s.st = st; s.o = o; s.mr = mr; s.fd = fd;
        q.push_back(s);
    endtask

    function automatic exp_t fetch_vec();
        exp_t x = '0;
        x.rs = 2'b10; x.a = 2'b01; x.b = 2'b10;
        return x;
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Expected cycle-by-cycle trace for one instruction.
    // fw/mw: wait cycles before mem_ready; fl: FP latency in cycles after fp_start (0 = never).
    task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] mull,
                         input logic [4:0] fpid, input int fw, input int mw, input int fl);
        exp_t x;
        logic is_mul, is_fp, trapped;
        int n;
        is_mul  = (op == 2'b00) && !fn[5] && (mull == 4'b1001);
        is_fp   = (op == 2'b00) && !fn[5] && (fpid == 5'b11111) && !is_mul;
        trapped = 1'b0;
        for (int i = 0; i < fw; i++) push(S_FETCH, fetch_vec(), 1'b0, rnd());
        x = fetch_vec(); x.np = 1'b1; x.irw = 1'b1;
        push(S_FETCH, x, 1'b1, rnd());
        push(S_DECODE, fetch_vec(), rnd(), rnd());
        exp_stall += CNT_W'(fw);
        case (op)
            2'b11: begin
                x = '0; x.tr = 1'b1; x.cause = 2'b01;
                push(S_UNKNOWN, x, rnd(), rnd());
                trapped = 1'b1;
            end
            2'b10: begin
                x = '0; x.br = 1'b1; x.rs = 2'b10; x.a = 2'b10; x.b = 2'b01;
                push(S_BRANCH, x, rnd(), rnd());
            end
            2'b01: begin
                x = '0; x.rs = 2'b10; x.b = 2'b01;
                push(S_MEMADR, x, rnd(), rnd());
                x = '0; x.adr = 1'b1; x.b = 2'b01; x.mw = !fn[0];
                for (int i = 0; i < mw; i++) push(fn[0] ? S_MEMRD : S_MEMWR, x, 1'b0, rnd());
                push(fn[0] ? S_MEMRD : S_MEMWR, x, 1'b1, rnd());
                exp_stall += CNT_W'(mw);
                if (fn[0]) begin
                    x = '0; x.rw = 1'b1; x.adr = 1'b1; x.rs = 2'b01; x.b = 2'b01;
                    push(S_MEMWB, x, rnd(), rnd());
                end
            end
            default: begin
                if (fn[5]) begin
                    x = '0; x.b = 2'b01; x.aop = 1'b1;
                    push(S_EXECUTEI, x, rnd(), rnd());
                end else begin
                    x = '0; x.rs = 2'b10; x.aop = 1'b1;
                    if (is_fp) begin
                        x.rc = 1'b1; x.fs = 1'b1;
                        push(S_EXECUTER, x, rnd(), rnd());
                        n = (fl >= 1 && fl <= int'(FP_TIMEOUT)) ? fl : int'(FP_TIMEOUT);
                        for (int k = 1; k <= n; k++) begin
                            x = '0; x.rc = 1'b1; x.aop = 1'b1;
                            if (k == n && k != fl) begin
                                x.tr = 1'b1; x.cause = 2'b10; trapped = 1'b1;
                            end
                            push(S_FPWAIT, x, rnd(), (k == fl));
                        end
                        exp_stall += CNT_W'(n);
                    end else if (is_mul) begin
                        x.ms = 1'b1;
                        push(S_EXECUTER, x, rnd(), rnd());
                        x.ms = 1'b0;
                        for (int i = 1; i < int'(MUL_CYCLES); i++) push(S_MULWAIT, x, rnd(), rnd());
                        exp_stall += CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        push(S_EXECUTER, x, rnd(), rnd());
                    end
                end
                if (!trapped) begin
                    x = '0; x.rw = 1'b1; x.aop = 1'b1;
                    x.we = is_mul & fn[3]; x.rc = is_fp;
                    push(S_ALUWB, x, rnd(), rnd());
                end
            end
        endcase
        if (!trapped) exp_ret += CNT_W'(1);
    endtask

    task automatic chk_counters();
`ifdef MAINFSM_PERF_CNT_EN
        chk("instr_retired", 32'(instr_retired), 32'(exp_ret));
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
`else
        chk("instr_retired", 32'(instr_retired), 32'd0);
        chk("stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    endtask

    task automatic play(input int limit);
        step_t s;
        int k = 0;
        while (q.size() > 0 && k < limit) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            fp_done   = s.fd;
            #1;
            chk($sformatf("state(%s)", s.st.name()), 32'(state_o), 32'(s.st));
            chk($sformatf("outs(%s)", s.st.name()), 32'(dut_outs), 32'(s.o));
            k++;
        end
    endtask

    // Starts in the FETCH cycle just after a clock edge so fields are stable before DECODE.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] mull,
                             input logic [4:0] fpid, input int fw, input int mw, input int fl,
                             input int limit);
        @(posedge clk);
        #1;
        chk_counters();
        Op = op; Funct = fn; MULL_Identifier = mull; FP_identifier = fpid;
        build(op, fn, mull, fpid, fw, mw, fl);
        play(limit);
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] mull,
                       input logic [4:0] fpid, input int fw, input int mw, input int fl);
        run_instr(op, fn, mull, fpid, fw, mw, fl, 1000);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; fp_done = 1'b0;
        Op = 2'b00; Funct = '0; MULL_Identifier = '0; FP_identifier = '0;
        #12;
        chk("reset_state", 32'(state_o), 32'(S_FETCH));
        chk("reset_outs", 32'(dut_outs), 32'(fetch_vec()));
        chk_counters();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("prestart_state", 32'(state_o), 32'(S_FETCH));
        chk("prestart_outs", 32'(dut_outs), 32'(fetch_vec()));

        // Immediate add, then register add, fetch wait, multiplies.
        run(2'b00, 6'b101000, 4'b0000, 5'b00000, 0, 0, 0);
        run(2'b00, 6'b001000, 4'b0000, 5'b00000, 0, 0, 0);
        run(2'b00, 6'b101000, 4'b0000, 5'b00000, 3, 0, 0);
        run(2'b00, 6'b001000, 4'b1001, 5'b00000, 0, 0, 0);
        run(2'b00, 6'b000000, 4'b1001, 5'b11111, 1, 0, 0);
        // FP: normal latency, never done, done in the timeout cycle.
        run(2'b00, 6'b000000, 4'b0000, 5'b11111, 0, 0, 4);
        run(2'b00, 6'b000000, 4'b0000, 5'b11111, 0, 0, 0);
        run(2'b00, 6'b000000, 4'b0000, 5'b11111, 0, 0, 15);
        run(2'b00, 6'b000000, 4'b0000, 5'b11111, 0, 0, 1);
        // Load, store, branch, illegal.
        run(2'b01, 6'b000001, 4'b0000, 5'b00000, 0, 2, 0);
        run(2'b01, 6'b000000, 4'b0000, 5'b00000, 0, 3, 0);
        run(2'b01, 6'b000001, 4'b0000, 5'b00000, 2, 0, 0);
        run(2'b10, 6'b000000, 4'b0000, 5'b00000, 0, 0, 0);
        run(2'b11, 6'b000000, 4'b0000, 5'b00000, 0, 0, 0);

        // Reset while in MULWAIT: FETCH at once with strobes quiet.
        run_instr(2'b00, 6'b001000, 4'b1001, 5'b00000, 0, 0, 0, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_state", 32'(state_o), 32'(S_FETCH));
        chk("midreset_outs", 32'(dut_outs), 32'(fetch_vec()));
        q.delete();
        exp_ret = '0;
        exp_stall = '0;
        chk_counters();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            logic [3:0] mull;
            logic [4:0] fpid;
            mull = ($urandom_range(0, 2) == 0) ? 4'b1001 : 4'($urandom);
            fpid = ($urandom_range(0, 2) == 0) ? 5'b11111 : 5'($urandom);
            run(2'($urandom), 6'($urandom), mull, fpid,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 18)));
        end

        @(posedge clk);
        #1;
        chk_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
